// File: rtl/i2c_bit_sequencer.sv
// I2C bit-level sequencer: shifts one byte out MSB first plus an ACK slot,
// generating SCL in four prescaled phases per bit and sampling SDA on the high phase.
module i2c_bit_sequencer #(
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      release_req,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [7:0]                tx_byte,
    input  logic                      sda_in,
    output logic                      scl_out,
    output logic                      sda_out,
    output logic                      busy,
    output logic                      done,
    output logic [7:0]                rx_byte,
    output logic                      ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BIT  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]                state;
    logic [PRESCALE_WIDTH-1:0] p_lat;
    logic [PRESCALE_WIDTH-1:0] pcnt;
    logic [7:0]                tx_lat;
    logic [1:0]                phase;
    logic [3:0]                bit_cnt;
    logic                      sda_q;
    logic                      accept;
    logic                      phase_end;
    logic [2:0]                next_bit;

    // start is honoured from IDLE and HOLD only, and outranks release_req in HOLD
    assign accept    = start && (state != ST_BIT);
    assign phase_end = (pcnt == p_lat);
    assign next_bit  = bit_cnt[2:0] + 3'd1;

    assign busy    = (state == ST_BIT);
    assign scl_out = (state == ST_BIT) ? phase[1] : (state != ST_HOLD);
    assign sda_out = sda_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            p_lat   <= '0;
            pcnt    <= '0;
            tx_lat  <= 8'h00;
            phase   <= 2'd0;
            bit_cnt <= 4'd0;
            sda_q   <= 1'b1;
            done    <= 1'b0;
            rx_byte <= 8'h00;
            ack     <= 1'b1;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state   <= ST_BIT;
                p_lat   <= prescale;
                tx_lat  <= tx_byte;
                pcnt    <= '0;
                phase   <= 2'd0;
                bit_cnt <= 4'd0;
                sda_q   <= tx_byte[7];
            end else begin
                case (state)
                    ST_IDLE: ;
                    ST_HOLD: if (release_req) state <= ST_IDLE;
                    ST_BIT: begin
                        if (phase_end) begin
                            pcnt  <= '0;
                            phase <= phase + 2'd1;
                        end else begin
                            pcnt <= pcnt + 1'b1;
                        end
                        // last cycle of the SCL-high phase 2: the bus level is settled
                        if (phase_end && phase == 2'd2) begin
                            if (bit_cnt[3]) ack <= sda_in;
                            else            rx_byte[~bit_cnt[2:0]] <= sda_in;
                        end
                        if (phase_end && phase == 2'd3) begin
                            if (bit_cnt[3]) begin
                                state <= ST_HOLD;
                                done  <= 1'b1;
                                sda_q <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                                sda_q   <= (bit_cnt == 4'd7) ? 1'b1 : tx_lat[~next_bit];
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_bit_sequencer.sv
// Self-checking bench for i2c_bit_sequencer: per-cycle SCL/SDA reference computed
// from bit/phase arithmetic, with rx_byte/ack predicted from the driven SDA levels.
module tb_i2c_bit_sequencer;

    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          release_req;
    logic [PW-1:0] prescale;
    logic [7:0]    tx_byte;
    logic          sda_in;
    logic          scl_out;
    logic          sda_out;
    logic          busy;
    logic          done;
    logic [7:0]    rx_byte;
    logic          ack;

    int            n_vec = 0;
    int            n_err = 0;
    logic [7:0]    last_rx;
    logic          last_ack;

    i2c_bit_sequencer #(.PRESCALE_WIDTH(PW)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .release_req (release_req),
        .prescale    (prescale),
        .tx_byte     (tx_byte),
        .sda_in      (sda_in),
        .scl_out     (scl_out),
        .sda_out     (sda_out),
        .busy        (busy),
        .done        (done),
        .rx_byte     (rx_byte),
        .ack         (ack)
    );

    always #5 clk = ~clk;

    // Called at a negedge. mode 0: SDA echoes the transmitted bit, ACK slot driven 0;
    // mode 1: SDA held high; mode 2: random SDA every cycle.
    task automatic run_transfer(input int p, input logic [7:0] tx, input int mode,
                                input bit with_release, input int glitch_t, input string name);
        int         per_bit;
        int         n;
        int         bitn;
        int         u;
        logic       exp_scl;
        logic       exp_sda;
        logic       drive;
        logic [7:0] exp_rx;
        logic       exp_ack;
        per_bit     = 4 * (p + 1);
        n           = 9 * per_bit;
        exp_rx      = 8'h00;
        exp_ack     = 1'b1;
        start       = 1'b1;
        release_req = with_release;
        prescale    = p[PW-1:0];
        tx_byte     = tx;
        @(negedge clk);
        start       = 1'b0;
        release_req = 1'b0;
        for (int t = 0; t < n; t++) begin
            if (t != 0) @(negedge clk);
            bitn    = t / per_bit;
            u       = t % per_bit;
            exp_scl = ((u / (p + 1)) >= 2);
            exp_sda = (bitn < 8) ? tx[7 - bitn] : 1'b1;
            n_vec++;
            if (busy !== 1'b1 || done !== 1'b0 || scl_out !== exp_scl || sda_out !== exp_sda) begin
                n_err++;
                $display("FAIL %s t=%0d: busy=%b done=%b scl=%b sda=%b, required busy=1 done=0 scl=%b sda=%b",
                         name, t, busy, done, scl_out, sda_out, exp_scl, exp_sda);
            end
            case (mode)
                0:       drive = (bitn < 8) ? exp_sda : 1'b0;
                1:       drive = 1'b1;
                default: drive = 1'($urandom_range(0, 1));
            endcase
            sda_in = drive;
            if (u == 3 * (p + 1) - 1) begin
                if (bitn < 8) exp_rx[7 - bitn] = drive;
                else          exp_ack = drive;
            end
            if (t == glitch_t) begin
                start    = 1'b1;
                prescale = 8'd7;
                tx_byte  = 8'($urandom);
            end else if (t == glitch_t + 1) begin
                start    = 1'b0;
                prescale = p[PW-1:0];
                tx_byte  = tx;
            end
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b1 || busy !== 1'b0 || scl_out !== 1'b0 || sda_out !== 1'b1 ||
            rx_byte !== exp_rx || ack !== exp_ack) begin
            n_err++;
            $display("FAIL %s end: done=%b busy=%b scl=%b sda=%b rx=%h ack=%b, required done=1 busy=0 scl=0 sda=1 rx=%h ack=%b",
                     name, done, busy, scl_out, sda_out, rx_byte, ack, exp_rx, exp_ack);
        end
        last_rx  = exp_rx;
        last_ack = exp_ack;
    endtask

    task automatic check_idle(input string name, input logic [7:0] exp_rx, input logic exp_ack);
        n_vec++;
        if (busy !== 1'b0 || done !== 1'b0 || scl_out !== 1'b1 || sda_out !== 1'b1 ||
            rx_byte !== exp_rx || ack !== exp_ack) begin
            n_err++;
            $display("FAIL %s: busy=%b done=%b scl=%b sda=%b rx=%h ack=%b, required busy=0 done=0 scl=1 sda=1 rx=%h ack=%b",
                     name, busy, done, scl_out, sda_out, rx_byte, ack, exp_rx, exp_ack);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; release_req = 1'b0;
        prescale = '0; tx_byte = 8'h00; sda_in = 1'b1;
        @(negedge clk);
        check_idle("reset_held", 8'h00, 1'b1);
        rst = 1'b0;
        release_req = 1'b1;
        @(negedge clk);
        check_idle("idle_after_reset", 8'h00, 1'b1);
        release_req = 1'b0;
    endtask

    task automatic test_basic_echo();
        run_transfer(0, 8'hA5, 0, 1'b0, -5, "p0_a5_echo");
    endtask

    task automatic test_prescale();
        run_transfer(3, 8'h3C, 1, 1'b0, -5, "p3_3c_high");
    endtask

    task automatic test_mid_start();
        // restart attempt during bit 4 with a different prescale must be ignored
        run_transfer(2, 8'($urandom), 2, 1'b0, 4 * 12 + 1, "mid_start_ignored");
    endtask

    task automatic test_back_to_back();
        run_transfer(1, 8'($urandom), 2, 1'b1, -5, "hold_start_with_release");
    endtask

    task automatic test_release();
        release_req = 1'b1;
        @(negedge clk);
        check_idle("release_to_idle", last_rx, last_ack);
        @(negedge clk);
        check_idle("release_in_idle", last_rx, last_ack);
        release_req = 1'b0;
        @(negedge clk);
        check_idle("idle_stays", last_rx, last_ack);
    endtask

    task automatic test_reset_mid_transfer();
        int p;
        int stop_t;
        p      = int'($urandom_range(0, 3));
        stop_t = 5 * 4 * (p + 1) + 2 * (p + 1);
        start = 1'b1; prescale = p[PW-1:0]; tx_byte = 8'($urandom);
        @(negedge clk);
        start = 1'b0;
        for (int t = 0; t < stop_t; t++) begin
            @(negedge clk);
            sda_in = 1'($urandom_range(0, 1));
        end
        #1 rst = 1'b1;
        #1;
        n_vec++;
        if (scl_out !== 1'b1 || sda_out !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: scl=%b sda=%b busy=%b done=%b, required scl=1 sda=1 busy=0 done=0",
                     scl_out, sda_out, busy, done);
        end
        @(negedge clk);
        check_idle("reset_mid_held", 8'h00, 1'b1);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("after_abort_no_done", 8'h00, 1'b1);
        end
        run_transfer(p, 8'($urandom), 2, 1'b0, -5, "after_abort_transfer");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            run_transfer(int'($urandom_range(0, 4)), 8'($urandom), 2, 1'($urandom_range(0, 1)), -5, "random");
            if (k % 2 == 1) test_release();
        end
    endtask

    initial begin
        test_reset();
        test_basic_echo();
        test_prescale();
        test_mid_start();
        test_back_to_back();
        test_release();
        test_reset_mid_transfer();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/i2c_bit_sequencer.md
I2C_BIT_SEQUENCER -- requirements
Module: i2c_bit_sequencer

Interface
REQ-001 SHALL have parameter PRESCALE_WIDTH, default 8: width of the phase prescale counter and of the prescale input.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1: request one 9-bit transfer (8 data bits, MSB first, then ACK).
REQ-005 SHALL have port release, input, 1: return the bus from HOLD to IDLE.
REQ-006 SHALL have port prescale, input, PRESCALE_WIDTH: phase length minus 1, in clk cycles.
REQ-007 SHALL have port tx_byte, input, 8: data to transmit.
REQ-008 SHALL have port sda_in, input, 1: sampled bus SDA level.
REQ-009 SHALL have port scl_out, output, 1: SCL drive level (1 = released/high).
REQ-010 SHALL have port sda_out, output, 1: SDA drive level (1 = released).
REQ-011 SHALL have port busy, output, 1: high while in BIT state.
REQ-012 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-013 SHALL have port rx_byte, output, 8: the 8 SDA samples taken during the data bits.
REQ-014 SHALL have port ack, output, 1: SDA sampled on bit 8 (0 = ACK, 1 = NACK).

Function
REQ-015 SHALL implement states IDLE (scl_out=1, sda_out=1), BIT (transfer) and HOLD (scl_out=0, sda_out=1).
REQ-016 SHALL, on start=1 in IDLE or HOLD, latch prescale and tx_byte, clear bit_cnt and phase, and enter BIT on the next edge; busy=1 from that edge.
REQ-017 SHALL ignore start while in BIT; latched prescale and tx_byte SHALL NOT change mid-transfer.
REQ-018 SHALL divide each bit into phases 0-3, each lasting P+1 cycles, where P is the latched prescale; P=0 gives 1-cycle phases.
REQ-019 SHALL drive scl_out=0 in phases 0-1 and scl_out=1 in phases 2-3.
REQ-020 SHALL update sda_out only at entry to phase 0: tx bit (7-bit_cnt) for bit_cnt 0-7, and 1 (released) for bit_cnt 8.
REQ-021 SHALL sample sda_in on the last cycle of phase 2: into rx_byte bit (7-bit_cnt) for bit_cnt 0-7, and into ack for bit_cnt 8.
REQ-022 SHALL increment bit_cnt (4 bits, range 0-8) at the end of phase 3, with no wrap past 8.
REQ-023 SHALL, at the end of phase 3 of bit 8, enter HOLD with done=1 for exactly one cycle and busy=0; BIT lasts 36*(P+1) cycles.
REQ-024 SHALL hold rx_byte and ack stable from done until the next start is accepted.
REQ-025 SHALL move from HOLD to IDLE on release=1; with start=1 and release=1 together in HOLD, start SHALL win.
REQ-026 SHALL treat release as a no-op in IDLE and BIT.
REQ-027 SHALL implement the prescale and bit counters as loadable/clearable registered counters: synchronous clear on start, increment enabled per phase or bit.

Reset
REQ-028 SHALL, while rst=1, force IDLE: scl_out=1, sda_out=1, busy=0, done=0, rx_byte=8'h00, ack=1, and all counters 0.
REQ-029 SHALL, on rst asserted mid-transfer, abort immediately with no done pulse, and resume from IDLE after rst deasserts.

Verification
REQ-030 SHALL cover this scenario: P=0, tx_byte=8'hA5, sda_in tied to sda_out except bit 8 sda_in=0 -> rx_byte=8'hA5, ack=0, done 36 cycles after busy rises, then HOLD with scl_out=0.
REQ-031 SHALL cover this scenario: P=3, tx_byte=8'h3C, sda_in=1 throughout -> scl period 16 cycles, done 144 cycles after busy rises, rx_byte=8'hFF, ack=1.
REQ-032 SHALL cover this scenario: start pulses at bit 4 of a transfer, with prescale changed to 7 -> no restart, timing unchanged, exactly one done pulse.
REQ-033 SHALL cover this scenario: in HOLD, start=1 and release=1 together -> new transfer begins, no IDLE cycle, scl_out stays 0.
REQ-034 SHALL cover this scenario: rst pulse during bit 5 phase 2 -> scl_out=1, sda_out=1, busy=0 asynchronously, no done; the next start completes normally.
REQ-035 SHALL cover this scenario: release in HOLD -> IDLE next edge, scl_out=1; release again in IDLE -> no change.
